// File: rtl/micro_tile_switch.sv
// micro_tile_switch
//   Owns NUM_TILES micro tiles and hands the clock, reset and I/O to exactly
//   one of them. A change of the (synchronised) select drains the current
//   tile (clock off), waits SETTLE_CYCLES, then clocks the new tile with its
//   reset held for RST_CYCLES before releasing it into RUN. An out-of-range
//   select parks the switch with every tile gated and in reset.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_sel_in       requested tile, asynchronous pin (synchronised inside)
//   i_ui_in        dedicated inputs routed to the active tile
//   i_tile_uo_out  flattened tile outputs, tile i at [i*IO_W +: IO_W]
//   o_tile_clk_en  per-tile clock enable for the external ICG cells
//   o_tile_rst_n   per-tile active-low reset
//   o_tile_ui_in   per-tile inputs, zero for tiles that are not clocked
//   o_uo_out       active tile output, zero unless running
//   o_active_sel   tile currently owned or being brought up
//   o_busy         high while draining, resetting or parked
//   o_switch_cnt   completed switches, wraps 255 -> 0
module micro_tile_switch #(
  parameter int NUM_TILES     = 4,
  parameter int SEL_W         = 2,
  parameter int IO_W          = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int RST_CYCLES    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [SEL_W-1:0]          i_sel_in,
  input  logic [IO_W-1:0]           i_ui_in,
  input  logic [NUM_TILES*IO_W-1:0] i_tile_uo_out,
  output logic [NUM_TILES-1:0]      o_tile_clk_en,
  output logic [NUM_TILES-1:0]      o_tile_rst_n,
  output logic [NUM_TILES*IO_W-1:0] o_tile_ui_in,
  output logic [IO_W-1:0]           o_uo_out,
  output logic [SEL_W-1:0]          o_active_sel,
  output logic                      o_busy,
  output logic [7:0]                o_switch_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_RESET = 2'd2,
    S_PARK  = 2'd3
  } state_t;

  localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] C_RST    = 4'(RST_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [SEL_W-1:0] r_active_sel;
  logic [SEL_W-1:0] r_sync1;
  logic [SEL_W-1:0] r_sync2;
  logic [7:0]       r_switch_cnt;
  // Set until the power-up bring-up of tile 0 leaves RESET; that bring-up
  // is not a switch and must not be counted.
  logic             r_first;

  logic w_sel_valid;
  logic w_sel_change;
  logic w_tile_live;
  logic w_run;

  // Extra leading zero so the compare works even when NUM_TILES == 2**SEL_W.
  assign w_sel_valid  = ({1'b0, r_sync2} < (SEL_W + 1)'(NUM_TILES));
  assign w_sel_change = (r_sync2 != r_active_sel);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_state      <= S_RESET;
      r_active_sel <= '0;
      r_cnt        <= C_RST;
      r_switch_cnt <= '0;
      r_first      <= 1'b1;
    end else begin
      r_sync1 <= i_sel_in;
      r_sync2 <= r_sync1;
      case (r_state)
        S_RESET: begin
          // Abort wins over completion so a tile is never released into
          // RUN only to be torn down again on the next cycle.
          if (w_sel_change) begin
            r_state <= S_DRAIN;
            r_cnt   <= C_SETTLE;
            r_first <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RUN;
            r_first <= 1'b0;
            if (!r_first) begin
              r_switch_cnt <= r_switch_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RUN: begin
          if (w_sel_change) begin
            r_state <= S_DRAIN;
            r_cnt   <= C_SETTLE;
          end
        end
        S_DRAIN: begin
          // Select is only looked at on exit; intermediate values are ignored.
          if (r_cnt == 4'd0) begin
            if (w_sel_valid) begin
              r_active_sel <= r_sync2;
              r_cnt        <= C_RST;
              r_state      <= S_RESET;
            end else begin
              r_state <= S_PARK;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_PARK: begin
          // Nothing is clocked while parked, so no drain gap is required.
          if (w_sel_valid) begin
            r_active_sel <= r_sync2;
            r_cnt        <= C_RST;
            r_state      <= S_RESET;
          end
        end
        default: r_state <= S_DRAIN;
      endcase
    end
  end

  // Gating with i_rst_n forces every tile off the instant reset asserts,
  // even though the state register itself resets into RESET.
  assign w_tile_live = i_rst_n && ((r_state == S_RESET) || (r_state == S_RUN));
  assign w_run       = i_rst_n && (r_state == S_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TILES; gi++) begin : g_tile
      logic w_sel_this;
      assign w_sel_this                      = (r_active_sel == SEL_W'(gi));
      assign o_tile_clk_en[gi]               = w_tile_live && w_sel_this;
      assign o_tile_rst_n[gi]                = w_run && w_sel_this;
      assign o_tile_ui_in[gi*IO_W +: IO_W]   = (w_tile_live && w_sel_this) ? i_ui_in : '0;
    end
  endgenerate

  // At most one tile is released from reset, so this is a plain one-hot mux.
  always_comb begin
    o_uo_out = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (w_run && (r_active_sel == SEL_W'(i))) begin
        o_uo_out = i_tile_uo_out[i*IO_W +: IO_W];
      end
    end
  end

  assign o_active_sel = r_active_sel;
  assign o_busy       = (r_state != S_RUN);
  assign o_switch_cnt = r_switch_cnt;

endmodule

// File: tb/tb_micro_tile_switch.sv
module tb_micro_tile_switch;

  localparam int SETTLE = 2;
  localparam int RSTC   = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel_a = 2'd0;
  logic [1:0]  sel_b = 2'd0;
  logic [7:0]  ui_in = 8'd0;
  logic [31:0] tuo   = 32'd0;

  logic [3:0]  a_en, a_rn;
  logic [31:0] a_tui;
  logic [7:0]  a_uo, a_cnt;
  logic [1:0]  a_act;
  logic        a_busy;

  logic [2:0]  b_en, b_rn;
  logic [23:0] b_tui;
  logic [7:0]  b_uo, b_cnt;
  logic [1:0]  b_act;
  logic        b_busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  micro_tile_switch #(
    .NUM_TILES(4), .SEL_W(2), .IO_W(8), .SETTLE_CYCLES(SETTLE), .RST_CYCLES(RSTC)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel_in(sel_a), .i_ui_in(ui_in),
    .i_tile_uo_out(tuo), .o_tile_clk_en(a_en), .o_tile_rst_n(a_rn),
    .o_tile_ui_in(a_tui), .o_uo_out(a_uo), .o_active_sel(a_act),
    .o_busy(a_busy), .o_switch_cnt(a_cnt)
  );

  micro_tile_switch #(
    .NUM_TILES(3), .SEL_W(2), .IO_W(8), .SETTLE_CYCLES(SETTLE), .RST_CYCLES(RSTC)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel_in(sel_b), .i_ui_in(ui_in),
    .i_tile_uo_out(tuo[23:0]), .o_tile_clk_en(b_en), .o_tile_rst_n(b_rn),
    .o_tile_ui_in(b_tui), .o_uo_out(b_uo), .o_active_sel(b_act),
    .o_busy(b_busy), .o_switch_cnt(b_cnt)
  );

  // ---------------- behavioural model (index 0: 4 tiles, 1: 3 tiles) -----
  typedef enum {P_UP, P_ON, P_GAP, P_IDLE} phase_t;
  phase_t m_ph[2];
  int     m_tile[2];
  int     m_left[2];
  int     m_done[2];
  bit     m_first[2];
  int     m_h1[2];
  int     m_h2[2];
  logic [3:0] prev_en[2];

  function automatic int nt(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic m_reset(int k);
    m_ph[k] = P_UP; m_tile[k] = 0; m_left[k] = RSTC; m_done[k] = 0;
    m_first[k] = 1'b1; m_h1[k] = 0; m_h2[k] = 0;
  endtask

  task automatic m_step(int k);
    int s;
    bit ok;
    s  = m_h2[k];
    ok = (s < nt(k));
    case (m_ph[k])
      P_UP: begin
        if (s != m_tile[k]) begin
          m_ph[k] = P_GAP; m_left[k] = SETTLE; m_first[k] = 1'b0;
        end else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            m_ph[k] = P_ON;
            if (!m_first[k]) m_done[k] = m_done[k] + 1;
            m_first[k] = 1'b0;
          end
        end
      end
      P_ON: begin
        if (s != m_tile[k]) begin
          m_ph[k] = P_GAP; m_left[k] = SETTLE;
        end
      end
      P_GAP: begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          if (ok) begin
            m_tile[k] = s; m_ph[k] = P_UP; m_left[k] = RSTC;
          end else begin
            m_ph[k] = P_IDLE;
          end
        end
      end
      P_IDLE: begin
        if (ok) begin
          m_tile[k] = s; m_ph[k] = P_UP; m_left[k] = RSTC;
        end
      end
      default: ;
    endcase
    m_h2[k] = m_h1[k];
    m_h1[k] = (k == 0) ? int'(sel_a) : int'(sel_b);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0); m_step(1);
    end
  end

  // ---------------- per-cycle compare ------------------------------------
  task automatic check_inst(int k);
    logic [3:0]  en, rn, xen, xrn;
    logic [31:0] tui, xtui;
    logic [7:0]  uo, xuo, cnt, xcnt;
    int          act, xact;
    bit          busy, xbusy;
    if (k == 0) begin
      en = a_en; rn = a_rn; tui = a_tui; uo = a_uo; act = int'(a_act);
      busy = a_busy; cnt = a_cnt;
    end else begin
      en = {1'b0, b_en}; rn = {1'b0, b_rn}; tui = {8'h00, b_tui}; uo = b_uo;
      act = int'(b_act); busy = b_busy; cnt = b_cnt;
    end
    xen = '0; xrn = '0; xtui = '0; xuo = '0;
    if (rst_n && (m_ph[k] == P_UP || m_ph[k] == P_ON)) begin
      xen[m_tile[k]] = 1'b1;
      xtui[m_tile[k]*8 +: 8] = ui_in;
    end
    if (rst_n && m_ph[k] == P_ON) begin
      xrn[m_tile[k]] = 1'b1;
      xuo = tuo[m_tile[k]*8 +: 8];
    end
    xact  = m_tile[k];
    xbusy = (m_ph[k] != P_ON);
    xcnt  = 8'(m_done[k]);
    checks++;
    if ({en, rn, tui, uo, act, busy, cnt} !== {xen, xrn, xtui, xuo, xact, xbusy, xcnt}) begin
      $display("FAIL model[%0d] t=%0t: got en=%b rn=%b tui=%h uo=%h act=%0d busy=%b cnt=%0d, expected en=%b rn=%b tui=%h uo=%h act=%0d busy=%b cnt=%0d",
               k, $time, en, rn, tui, uo, act, busy, cnt, xen, xrn, xtui, xuo, xact, xbusy, xcnt);
    end else begin
      passes++;
    end
    // Structural properties: onehot0, no back-to-back handover, quiet uo_out.
    checks++;
    if (!$onehot0(en) || (prev_en[k] != 4'd0 && en != 4'd0 && prev_en[k] != en) ||
        (busy && uo != 8'd0)) begin
      $display("FAIL props[%0d] t=%0t: got en=%b prev_en=%b busy=%b uo=%h, expected onehot0, no direct handover, uo=0 when busy",
               k, $time, en, prev_en[k], busy, uo);
    end else begin
      passes++;
    end
    prev_en[k] = en;
  endtask

  always @(negedge clk) begin
    check_inst(0);
    check_inst(1);
  end

  // ---------------- directed literal checks ------------------------------
  task automatic lit(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      passes++;
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    m_reset(0); m_reset(1);
    prev_en[0] = '0; prev_en[1] = '0;

    // Power-up
    tick(3);
    rst_n = 1'b1;
    #1;
    lit("pu_en_first", 32'(a_en), 32'h1);
    lit("pu_rstn_low", 32'(a_rn), 32'h0);
    tick(3);
    lit("pu_en_last", 32'(a_en), 32'h1);
    lit("pu_busy", 32'(a_busy), 32'h1);
    tick(1);
    tuo = 32'h0000_00A5;
    #1;
    lit("pu_run_rstn", 32'(a_rn), 32'h1);
    lit("pu_uo", 32'(a_uo), 32'hA5);
    lit("pu_swcnt", 32'(a_cnt), 32'h0);

    // Switch 0 -> 2
    sel_a = 2'd2; ui_in = 8'h3C;
    tick(2);
    lit("sw_still_run", 32'(a_busy), 32'h0);
    tick(1);
    lit("sw_drain_en", 32'(a_en), 32'h0);
    lit("sw_drain_busy", 32'(a_busy), 32'h1);
    tick(1);
    lit("sw_drain_en2", 32'(a_en), 32'h0);
    tick(1);
    lit("sw_reset_en", 32'(a_en), 32'h4);
    lit("sw_reset_rstn", 32'(a_rn), 32'h0);
    lit("sw_reset_tui", a_tui, 32'h003C_0000);
    tick(3);
    lit("sw_reset_en_last", 32'(a_en), 32'h4);
    tick(1);
    lit("sw_run_rstn", 32'(a_rn), 32'h4);
    lit("sw_run_busy", 32'(a_busy), 32'h0);
    lit("sw_run_swcnt", 32'(a_cnt), 32'h1);
    lit("sw_run_tui", a_tui, 32'h003C_0000);

    // Abort during RESET: 2 -> 1, then 3 in the second RESET cycle
    sel_a = 2'd1;
    tick(5);
    lit("ab_reset_en", 32'(a_en), 32'h2);
    tick(1);
    sel_a = 2'd3;
    tick(3);
    lit("ab_drain_en", 32'(a_en), 32'h0);
    lit("ab_drain_busy", 32'(a_busy), 32'h1);
    tick(2);
    lit("ab_reset3_en", 32'(a_en), 32'h8);
    tick(4);
    lit("ab_run3_rstn", 32'(a_rn), 32'h8);
    lit("ab_run3_act", 32'(a_act), 32'h3);
    lit("ab_swcnt", 32'(a_cnt), 32'h2);

    // Invalid select on the 3-tile instance -> PARK, then tile 1
    tuo = 32'hDEAD_BEEF;
    sel_b = 2'd3;
    tick(5);
    lit("pk_en", 32'(b_en), 32'h0);
    lit("pk_uo", 32'(b_uo), 32'h0);
    lit("pk_busy", 32'(b_busy), 32'h1);
    tick(3);
    lit("pk_hold_busy", 32'(b_busy), 32'h1);
    sel_b = 2'd1;
    tick(3);
    lit("pk_reset1_en", 32'(b_en), 32'h2);
    lit("pk_reset1_rstn", 32'(b_rn), 32'h0);
    tick(4);
    lit("pk_run1_rstn", 32'(b_rn), 32'h2);
    lit("pk_run1_uo", 32'(b_uo), 32'hBE);
    lit("pk_run1_swcnt", 32'(b_cnt), 32'h1);

    // Async reset in the middle of RUN on tile 2
    sel_a = 2'd2;
    tick(9);
    lit("ar_run2_rstn", 32'(a_rn), 32'h4);
    rst_n = 1'b0;
    #1;
    lit("ar_en_now", 32'(a_en), 32'h0);
    lit("ar_rstn_now", 32'(a_rn), 32'h0);
    sel_a = 2'd0; sel_b = 2'd0;
    tick(2);
    rst_n = 1'b1;
    #1;
    lit("ar_rebringup_en", 32'(a_en), 32'h1);
    lit("ar_swcnt", 32'(a_cnt), 32'h0);

    // Randomised phase
    for (int c = 0; c < 10000; c++) begin
      tick(1);
      ui_in = 8'($urandom);
      tuo   = $urandom;
      if ($urandom_range(0, 39) == 0) sel_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) sel_b = 2'($urandom_range(0, 3));
      if (!rst_n) begin
        if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 2999) == 0) begin
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    tick(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
